cdb_arbiter: RTL and testbench
==============================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter NUM_SRC, default 4, number of requesting functional units (load buffer, reservation stations).
REQ-002 SHALL have parameter DATA_WIDTH, default 16, broadcast data width.
REQ-003 SHALL have parameter TAG_WIDTH, default 3, ROB-address tag width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port flush  input  1  pipeline flush from ROB (mispredict).
REQ-007 SHALL have port req_valid  input  NUM_SRC  per-source result-ready request.
REQ-008 SHALL have port req_tag  input  NUM_SRC*TAG_WIDTH  per-source destination ROB tag, source i at bits [i*TAG_WIDTH +: TAG_WIDTH].
REQ-009 SHALL have port req_data  input  NUM_SRC*DATA_WIDTH  per-source result, source i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-010 SHALL have port grant  output  NUM_SRC  one-hot acceptance of a source's request this cycle.
REQ-011 SHALL have port cdb_valid  output  1  CDB broadcast valid.
REQ-012 SHALL have port cdb_tag  output  TAG_WIDTH  CDB broadcast tag.
REQ-013 SHALL have port cdb_data  output  DATA_WIDTH  CDB broadcast data.
REQ-014 SHALL have port conflict_count  output  16  saturating count of cycles with a denied request.

Function
REQ-015 grant SHALL be combinational from req_valid, rr_ptr and flush; at most one bit set per cycle.
REQ-016 Selection SHALL be round-robin: winner is the first asserted req_valid at index rr_ptr, rr_ptr+1, ... modulo NUM_SRC.
REQ-017 After a grant to source k, rr_ptr SHALL become (k+1) mod NUM_SRC on the next edge; with no grant rr_ptr SHALL hold.
REQ-018 Handshake: a source SHALL hold req_valid, req_tag, req_data stable until it sees grant; the request is consumed in the grant cycle; the source may present a new request the following cycle.
REQ-019 On grant to k, cdb_valid/cdb_tag/cdb_data SHALL on the next edge take 1/req_tag[k]/req_data[k]; latency request-to-broadcast is exactly 1 cycle when uncontended.
REQ-020 With no grant, cdb_valid SHALL go 0 on the next edge; cdb_tag/cdb_data SHALL hold last value.
REQ-021 cdb_valid SHALL be a single-cycle pulse per grant; back-to-back grants SHALL give consecutive broadcast cycles (one result per cycle throughput).
REQ-022 When flush=1, grant SHALL be all-zero, cdb_valid SHALL be 0 on the next edge, rr_ptr SHALL reset to 0; conflict_count SHALL hold.
REQ-023 Flush SHALL NOT drop a broadcast already registered before the flush edge (it completes its cycle); requests present during flush are not consumed.
REQ-024 conflict_count SHALL increment by 1 on each non-flush cycle where popcount(req_valid) >= 2, and SHALL saturate at 16'hFFFF.
REQ-025 A request asserted at rr_ptr SHALL be granted within NUM_SRC cycles of assertion (no starvation).
REQ-026 req_valid on a single source SHALL be granted every cycle it is asserted regardless of rr_ptr.

Reset
REQ-027 While rst=1 (asynchronously): cdb_valid=0, cdb_tag=0, cdb_data=0, rr_ptr=0, conflict_count=0, grant all-zero.
REQ-028 Reset asserted mid-broadcast SHALL clear cdb_valid immediately; pending requests are not granted until rst deasserts, then arbitration restarts from source 0.

Verification
REQ-029 Reset, then req_valid=4'b0100, tag=5, data=16'h1234 -> grant=4'b0100 that cycle; next cycle cdb_valid=1, tag=5, data=16'h1234; following cycle cdb_valid=0.
REQ-030 req_valid=4'b1111 held 4 cycles from rr_ptr=0 (each source drops after grant, reasserts) -> grants 0,1,2,3 in order; cdb_valid high 4 consecutive cycles; conflict_count=3 (last cycle single request... counted only when >=2 active).
REQ-031 Source 3 requests constantly, sources 0-2 toggle continuously -> source 3 granted within 4 cycles of each reassertion.
REQ-032 flush=1 with req_valid=4'b0011 -> grant=0, next cycle cdb_valid=0, rr_ptr=0; after flush, source 0 granted first.
REQ-033 Force 65536 contended cycles -> conflict_count=16'hFFFF and holds.
REQ-034 Assert rst asynchronously between edges while cdb_valid=1 -> cdb_valid=0 before next edge, conflict_count=0.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: round-robin selection of one functional-unit
// result per cycle, registered broadcast, and a saturating conflict count.
module cdb_arbiter #(
  parameter int NUM_SRC    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int TAG_WIDTH  = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic [NUM_SRC-1:0]            req_valid,
  input  logic [NUM_SRC*TAG_WIDTH-1:0]  req_tag,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] req_data,
  output logic [NUM_SRC-1:0]            grant,
  output logic                          cdb_valid,
  output logic [TAG_WIDTH-1:0]          cdb_tag,
  output logic [DATA_WIDTH-1:0]         cdb_data,
  output logic [15:0]                   conflict_count
);

  localparam int PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [PW-1:0]         r_rr_ptr;
  logic                  r_valid;
  logic [TAG_WIDTH-1:0]  r_tag;
  logic [DATA_WIDTH-1:0] r_data;
  logic [15:0]           r_conf;

  logic [NUM_SRC-1:0]    w_grant;
  logic                  w_any;
  logic [PW-1:0]         w_next_ptr;
  logic [TAG_WIDTH-1:0]  w_tag;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  w_contend;

  // Round-robin search from r_rr_ptr; reset and flush suppress any grant
  always_comb begin
    int j;
    int n;
    w_grant    = '0;
    w_any      = 1'b0;
    w_next_ptr = r_rr_ptr;
    w_tag      = '0;
    w_data     = '0;
    n          = 0;
    for (int i = 0; i < NUM_SRC; i++) begin
      j = int'(r_rr_ptr) + i;
      if (j >= NUM_SRC) j = j - NUM_SRC;
      if (!w_any && req_valid[j] && !flush && !rst) begin
        w_any      = 1'b1;
        w_grant[j] = 1'b1;
        w_tag      = req_tag[j*TAG_WIDTH +: TAG_WIDTH];
        w_data     = req_data[j*DATA_WIDTH +: DATA_WIDTH];
        w_next_ptr = (j + 1 >= NUM_SRC) ? '0 : PW'(j + 1);
      end
      if (req_valid[i]) n = n + 1;
    end
    w_contend = (n >= 2);
  end

  // Pointer advance and single-cycle broadcast register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr <= '0;
      r_valid  <= 1'b0;
      r_tag    <= '0;
      r_data   <= '0;
    end else if (flush) begin
      r_rr_ptr <= '0;
      r_valid  <= 1'b0;
    end else if (w_any) begin
      r_rr_ptr <= w_next_ptr;
      r_valid  <= 1'b1;
      r_tag    <= w_tag;
      r_data   <= w_data;
    end else begin
      r_valid  <= 1'b0;
    end
  end

  // Saturating count of cycles where some request had to wait
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_conf <= '0;
    end else if (!flush && w_contend && r_conf != 16'hFFFF) begin
      r_conf <= r_conf + 16'd1;
    end
  end

  assign grant          = w_grant;
  assign cdb_valid      = r_valid;
  assign cdb_tag        = r_tag;
  assign cdb_data       = r_data;
  assign conflict_count = r_conf;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: grants, broadcast timing, flush,
// fairness, counter saturation and asynchronous reset.
module tb_cdb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [3:0]  req_valid;
  logic [11:0] req_tag;
  logic [63:0] req_data;
  logic [3:0]  grant;
  logic        cdb_valid;
  logic [2:0]  cdb_tag;
  logic [15:0] cdb_data;
  logic [15:0] conflict_count;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_cnt = 16'd0;

  cdb_arbiter #(.NUM_SRC(4), .DATA_WIDTH(16), .TAG_WIDTH(3)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_tag(req_tag), .req_data(req_data),
    .grant(grant), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_data(cdb_data), .conflict_count(conflict_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic [2:0] t,
                         input logic [15:0] d);
    req_tag[i*3 +: 3]   = t;
    req_data[i*16 +: 16] = d;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0;
    req_valid = 4'b1111; req_tag = '0; req_data = '0;
    #2;
    n_checks++;
    if (grant !== 4'b0000) begin
      n_fail++; $display("FAIL reset_grant got %b want 0000", grant);
    end
    step();
    n_checks++;
    if (cdb_valid !== 1'b0 || cdb_tag !== 3'd0 || cdb_data !== 16'h0 ||
        conflict_count !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_state got v=%b t=%0d d=%h c=%0d want 0/0/0/0",
               cdb_valid, cdb_tag, cdb_data, conflict_count);
    end
    req_valid = 4'b0000;
    rst = 1'b0;
  endtask

  task automatic test_single();
    set_src(2, 3'd5, 16'h1234);
    req_valid = 4'b0100;
    #1;
    n_checks++;
    if (grant !== 4'b0100) begin
      n_fail++; $display("FAIL single_grant got %b want 0100", grant);
    end
    step();
    n_checks++;
    if (cdb_valid !== 1'b1 || cdb_tag !== 3'd5 || cdb_data !== 16'h1234) begin
      n_fail++;
      $display("FAIL single_bcast got v=%b t=%0d d=%h want 1/5/1234",
               cdb_valid, cdb_tag, cdb_data);
    end
    req_valid = 4'b0000;
    step();
    n_checks++;
    if (cdb_valid !== 1'b0 || cdb_tag !== 3'd5 || cdb_data !== 16'h1234) begin
      n_fail++;
      $display("FAIL single_drop got v=%b t=%0d d=%h want 0/5/1234",
               cdb_valid, cdb_tag, cdb_data);
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [3:0] e;
    for (int i = 0; i < 4; i++) set_src(i, 3'(i + 1), 16'hA000 + 16'(i));
    req_valid = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      #1;
      e = 4'b0001 << k;
      n_checks++;
      if (grant !== e) begin
        n_fail++; $display("FAIL rr_grant%0d got %b want %b", k, grant, e);
      end
      step();
      n_checks++;
      if (cdb_valid !== 1'b1 || cdb_tag !== 3'(k + 1) ||
          cdb_data !== 16'hA000 + 16'(k)) begin
        n_fail++;
        $display("FAIL rr_bcast%0d got v=%b t=%0d d=%h", k,
                 cdb_valid, cdb_tag, cdb_data);
      end
      req_valid[k] = 1'b0;
    end
    exp_cnt = exp_cnt + 16'd3;
    n_checks++;
    if (conflict_count !== exp_cnt) begin
      n_fail++;
      $display("FAIL rr_conflicts got %0d want %0d", conflict_count, exp_cnt);
    end
    step();
    n_checks++;
    if (cdb_valid !== 1'b0) begin
      n_fail++; $display("FAIL rr_end_valid got %b want 0", cdb_valid);
    end
  endtask

  task automatic test_single_any_ptr();
    set_src(2, 3'd6, 16'h0BEE);
    req_valid = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++;
      if (grant !== 4'b0100) begin
        n_fail++; $display("FAIL lone_grant%0d got %b want 0100", k, grant);
      end
      step();
      n_checks++;
      if (cdb_valid !== 1'b1 || cdb_tag !== 3'd6) begin
        n_fail++;
        $display("FAIL lone_bcast%0d got v=%b t=%0d want 1/6", k,
                 cdb_valid, cdb_tag);
      end
    end
    req_valid = 4'b0000;
    step();
  endtask

  task automatic test_starvation();
    int waited = 0;
    for (int c = 0; c < 12; c++) begin
      req_valid = (c % 2 == 0) ? 4'b1111 : 4'b1000;
      #1;
      waited++;
      n_checks++;
      if (!$onehot(grant)) begin
        n_fail++; $display("FAIL starve_onehot c%0d got %b", c, grant);
      end
      if (grant[3]) begin
        n_checks++;
        if (waited > 4) begin
          n_fail++;
          $display("FAIL starve_wait c%0d got %0d want <=4", c, waited);
        end
        waited = 0;
      end
      step();
    end
    exp_cnt = exp_cnt + 16'd6;
    req_valid = 4'b0000;
    n_checks++;
    if (waited >= 4 || conflict_count !== exp_cnt) begin
      n_fail++;
      $display("FAIL starve_end got wait=%0d cnt=%0d want <4/%0d",
               waited, conflict_count, exp_cnt);
    end
    step();
  endtask

  task automatic test_flush();
    set_src(0, 3'd1, 16'h00F0);
    set_src(1, 3'd2, 16'h00F1);
    req_valid = 4'b0001;
    step();
    flush = 1'b1;
    req_valid = 4'b0011;
    #1;
    n_checks++;
    if (grant !== 4'b0000 || cdb_valid !== 1'b1 || cdb_tag !== 3'd1) begin
      n_fail++;
      $display("FAIL flush_cycle got g=%b v=%b t=%0d want 0000/1/1",
               grant, cdb_valid, cdb_tag);
    end
    step();
    n_checks++;
    if (cdb_valid !== 1'b0 || conflict_count !== exp_cnt) begin
      n_fail++;
      $display("FAIL flush_after got v=%b cnt=%0d want 0/%0d",
               cdb_valid, conflict_count, exp_cnt);
    end
    flush = 1'b0;
    #1;
    n_checks++;
    if (grant !== 4'b0001) begin
      n_fail++; $display("FAIL flush_restart got %b want 0001", grant);
    end
    step();
    exp_cnt = exp_cnt + 16'd1;
    n_checks++;
    if (cdb_valid !== 1'b1 || cdb_data !== 16'h00F0 ||
        conflict_count !== exp_cnt) begin
      n_fail++;
      $display("FAIL flush_bcast got v=%b d=%h cnt=%0d want 1/00f0/%0d",
               cdb_valid, cdb_data, conflict_count, exp_cnt);
    end
    req_valid = 4'b0010;
    #1;
    n_checks++;
    if (grant !== 4'b0010) begin
      n_fail++; $display("FAIL flush_second got %b want 0010", grant);
    end
    step();
    req_valid = 4'b0000;
    step();
  endtask

  task automatic test_saturate();
    req_valid = 4'b1111;
    repeat (65540) step();
    n_checks++;
    if (conflict_count !== 16'hFFFF) begin
      n_fail++; $display("FAIL sat_reach got %h want ffff", conflict_count);
    end
    repeat (3) step();
    n_checks++;
    if (conflict_count !== 16'hFFFF) begin
      n_fail++; $display("FAIL sat_hold got %h want ffff", conflict_count);
    end
    req_valid = 4'b0000;
    step();
  endtask

  task automatic test_async_reset();
    set_src(0, 3'd7, 16'hCAFE);
    set_src(1, 3'd3, 16'h0333);
    req_valid = 4'b0001;
    step();
    n_checks++;
    if (cdb_valid !== 1'b1 || cdb_tag !== 3'd7) begin
      n_fail++;
      $display("FAIL arst_pre got v=%b t=%0d want 1/7", cdb_valid, cdb_tag);
    end
    req_valid = 4'b1010;
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (cdb_valid !== 1'b0 || conflict_count !== 16'h0 ||
        cdb_tag !== 3'd0 || grant !== 4'b0000) begin
      n_fail++;
      $display("FAIL arst_now got v=%b c=%0d t=%0d g=%b want 0/0/0/0000",
               cdb_valid, conflict_count, cdb_tag, grant);
    end
    step();
    rst = 1'b0;
    #1;
    n_checks++;
    if (grant !== 4'b0010) begin
      n_fail++; $display("FAIL arst_restart got %b want 0010", grant);
    end
    step();
    n_checks++;
    if (cdb_valid !== 1'b1 || cdb_data !== 16'h0333 ||
        conflict_count !== 16'd1) begin
      n_fail++;
      $display("FAIL arst_bcast got v=%b d=%h c=%0d want 1/0333/1",
               cdb_valid, cdb_data, conflict_count);
    end
    req_valid = 4'b0000;
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_single_any_ptr();
    test_starvation();
    test_flush();
    test_saturate();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
